// File: rtl/osd_stm_trace_arbiter.sv
// Arbitrates NUM_SRC single-cycle trace requesters onto one STM trace port.
// Optional build macro OSD_STM_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module osd_stm_trace_arbiter #(
    parameter int NUM_SRC   = 4,
    parameter int XLEN      = 64,
    parameter int CNT_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SRC-1:0]            src_enable,
    input  logic [NUM_SRC-1:0]            src_valid,
    input  logic [NUM_SRC*16-1:0]         src_id,
    input  logic [NUM_SRC*XLEN-1:0]       src_value,
    input  logic [NUM_SRC-1:0]            drop_clr,
    output logic [NUM_SRC*CNT_WIDTH-1:0]  drop_count,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(NUM_SRC)-1:0]    out_src,
    output logic [15:0]                   out_id,
    output logic [XLEN-1:0]               out_value,
    output logic                          out_lost
);

    localparam int SW = $clog2(NUM_SRC);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [NUM_SRC-1:0]   pending_q, pending_d;
    logic [NUM_SRC-1:0]   lost_q, lost_d;
    logic [15:0]          hold_id_q    [NUM_SRC];
    logic [15:0]          hold_id_d    [NUM_SRC];
    logic [XLEN-1:0]      hold_value_q [NUM_SRC];
    logic [XLEN-1:0]      hold_value_d [NUM_SRC];
    logic [CNT_WIDTH-1:0] drop_cnt_q   [NUM_SRC];
    logic [CNT_WIDTH-1:0] drop_cnt_d   [NUM_SRC];

    logic                 out_valid_q, out_valid_d;
    logic [SW-1:0]        out_src_q, out_src_d;
    logic [15:0]          out_id_q, out_id_d;
    logic [XLEN-1:0]      out_value_q, out_value_d;
    logic                 out_lost_q, out_lost_d;

    logic                 load;
    logic                 grant_any;
    logic [SW-1:0]        winner;
    logic [NUM_SRC-1:0]   cap;
    logic [NUM_SRC-1:0]   granted;
    logic [NUM_SRC-1:0]   drop;

`ifndef OSD_STM_ARB_FIXED_PRIO_EN
    logic [SW-1:0]        ptr_q, ptr_d;
    logic [SW:0]          rr_sum;
    logic [SW-1:0]        rr_idx;
`endif

    assign load = !out_valid_q || out_ready;
    assign cap  = src_valid & src_enable;

    // Scan from highest to lowest candidate so the last hit is the preferred one.
    always_comb begin
        grant_any = 1'b0;
        winner    = '0;
`ifdef OSD_STM_ARB_FIXED_PRIO_EN
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                grant_any = 1'b1;
                winner    = SW'(i);
            end
        end
`else
        rr_sum = '0;
        rr_idx = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            rr_sum = {1'b0, ptr_q} + (SW+1)'(k);
            if (rr_sum >= (SW+1)'(NUM_SRC)) begin
                rr_sum = rr_sum - (SW+1)'(NUM_SRC);
            end
            rr_idx = rr_sum[SW-1:0];
            if (pending_q[rr_idx]) begin
                grant_any = 1'b1;
                winner    = rr_idx;
            end
        end
`endif
    end

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            granted[i] = load && grant_any && (winner == SW'(i));
            drop[i]    = cap[i] && pending_q[i] && !granted[i];
        end
    end

    always_comb begin
        pending_d    = pending_q;
        lost_d       = lost_q;
        hold_id_d    = hold_id_q;
        hold_value_d = hold_value_q;
        drop_cnt_d   = drop_cnt_q;
        out_valid_d  = out_valid_q;
        out_src_d    = out_src_q;
        out_id_d     = out_id_q;
        out_value_d  = out_value_q;
        out_lost_d   = out_lost_q;

        if (load) begin
            out_valid_d = grant_any;
            if (grant_any) begin
                out_src_d         = winner;
                out_id_d          = hold_id_q[winner];
                out_value_d       = hold_value_q[winner];
                out_lost_d        = lost_q[winner];
                pending_d[winner] = 1'b0;
                lost_d[winner]    = 1'b0;
            end
        end

        // Captures and drops are applied after the grant so they win over its clear.
        for (int i = 0; i < NUM_SRC; i++) begin
            if (cap[i] && !drop[i]) begin
                hold_id_d[i]    = src_id[16*i +: 16];
                hold_value_d[i] = src_value[XLEN*i +: XLEN];
                pending_d[i]    = 1'b1;
            end
            if (drop[i]) begin
                lost_d[i] = 1'b1;
            end
            if (drop_clr[i]) begin
                drop_cnt_d[i] = drop[i] ? CNT_WIDTH'(1) : '0;
            end else if (drop[i] && drop_cnt_q[i] != CNT_MAX) begin
                drop_cnt_d[i] = drop_cnt_q[i] + 1'b1;
            end
        end
    end

`ifndef OSD_STM_ARB_FIXED_PRIO_EN
    always_comb begin
        ptr_d = ptr_q;
        if (load && grant_any) begin
            ptr_d = (winner == SW'(NUM_SRC - 1)) ? '0 : winner + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q   <= '0;
            lost_q      <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                hold_id_q[i]    <= '0;
                hold_value_q[i] <= '0;
                drop_cnt_q[i]   <= '0;
            end
            out_valid_q <= 1'b0;
            out_src_q   <= '0;
            out_id_q    <= '0;
            out_value_q <= '0;
            out_lost_q  <= 1'b0;
        end else begin
            pending_q    <= pending_d;
            lost_q       <= lost_d;
            hold_id_q    <= hold_id_d;
            hold_value_q <= hold_value_d;
            drop_cnt_q   <= drop_cnt_d;
            out_valid_q  <= out_valid_d;
            out_src_q    <= out_src_d;
            out_id_q     <= out_id_d;
            out_value_q  <= out_value_d;
            out_lost_q   <= out_lost_d;
        end
    end

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_cnt_out
        assign drop_count[CNT_WIDTH*g +: CNT_WIDTH] = drop_cnt_q[g];
    end

    assign out_valid = out_valid_q;
    assign out_src   = out_src_q;
    assign out_id    = out_id_q;
    assign out_value = out_value_q;
    assign out_lost  = out_lost_q;

endmodule

// File: tb/tb_osd_stm_trace_arbiter.sv
// Scoreboard bench for osd_stm_trace_arbiter: expected events are queued at stimulus
// time and popped whenever the STM side accepts an event.
module tb_osd_stm_trace_arbiter;

    localparam int NUM_SRC = 4;
    localparam int XLEN    = 64;
    localparam int CW      = 8;

    logic                    clk;
    logic                    rst;
    logic [NUM_SRC-1:0]      src_enable;
    logic [NUM_SRC-1:0]      src_valid;
    logic [NUM_SRC*16-1:0]   src_id;
    logic [NUM_SRC*XLEN-1:0] src_value;
    logic [NUM_SRC-1:0]      drop_clr;
    logic [NUM_SRC*CW-1:0]   drop_count;
    logic                    out_valid;
    logic                    out_ready;
    logic [1:0]              out_src;
    logic [15:0]             out_id;
    logic [XLEN-1:0]         out_value;
    logic                    out_lost;

    typedef struct {
        logic [1:0]      src;
        logic [15:0]     id;
        logic [XLEN-1:0] value;
        logic            lost;
    } exp_t;

    exp_t sb[$];
    exp_t e_mon;
    int   n_vec = 0;
    int   n_err = 0;

    osd_stm_trace_arbiter #(.NUM_SRC(NUM_SRC), .XLEN(XLEN), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .src_enable (src_enable),
        .src_valid  (src_valid),
        .src_id     (src_id),
        .src_value  (src_value),
        .drop_clr   (drop_clr),
        .drop_count (drop_count),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_src    (out_src),
        .out_id     (out_id),
        .out_value  (out_value),
        .out_lost   (out_lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic [15:0] id, input logic [XLEN-1:0] v);
        src_id[16*i +: 16]      = id;
        src_value[XLEN*i +: XLEN] = v;
    endtask

    task automatic push(input int s, input logic [15:0] id, input logic [XLEN-1:0] v, input logic lost);
        exp_t e;
        e.src   = 2'(s);
        e.id    = id;
        e.value = v;
        e.lost  = lost;
        sb.push_back(e);
    endtask

    function automatic logic [CW-1:0] cnt(input int i);
        return drop_count[CW*i +: CW];
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Accept happens at the next rising edge whenever valid and ready are both high here.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("spurious", 64'(out_valid), 64'd0);
            end else begin
                e_mon = sb.pop_front();
                chk("sb_src",   64'(out_src),   64'(e_mon.src));
                chk("sb_id",    64'(out_id),    64'(e_mon.id));
                chk("sb_value", 64'(out_value), 64'(e_mon.value));
                chk("sb_lost",  64'(out_lost),  64'(e_mon.lost));
            end
        end
    end

    initial begin
        rst        = 1'b1;
        src_enable = '1;
        src_valid  = '0;
        src_id     = '0;
        src_value  = '0;
        drop_clr   = '0;
        out_ready  = 1'b1;
        tick();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_id",    64'(out_id),    64'd0);
        chk("rst_value", 64'(out_value), 64'd0);
        chk("rst_cnt",   64'(drop_count), 64'd0);
        tick();
        rst = 1'b0;
        tick();

        // Single event on source 2: latency and one-cycle valid.
        set_src(2, 16'h0010, 64'hAB);
        src_valid = 4'b0100;
        push(2, 16'h0010, 64'hAB, 1'b0);
        tick();
        src_valid = '0;
        chk("lat_early", 64'(out_valid), 64'd0);
        tick();
        chk("lat_valid", 64'(out_valid), 64'd1);
        chk("lat_src",   64'(out_src),   64'd2);
        chk("lat_id",    64'(out_id),    64'h10);
        chk("lat_value", 64'(out_value), 64'hAB);
        chk("lat_lost",  64'(out_lost),  64'd0);
        tick();
        chk("lat_idle",  64'(out_valid), 64'd0);

        // Two all-source bursts from a fresh pointer.
        do_reset();
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                set_src(i, 16'(16'h100 * (b + 1) + i), 64'(64'h1000 * (b + 1) + i));
                push(i, 16'(16'h100 * (b + 1) + i), 64'(64'h1000 * (b + 1) + i), 1'b0);
            end
            src_valid = '1;
            tick();
            src_valid = '0;
            repeat (6) tick();
            chk("burst_drain", 64'(sb.size()), 64'd0);
        end

        // Source 0 re-requests while source 1 waits: policy decides the order.
        set_src(0, 16'h0300, 64'h300);
        set_src(1, 16'h0301, 64'h301);
        src_valid = 4'b0011;
        tick();
        set_src(0, 16'h0302, 64'h302);
        src_valid = 4'b0001;
        tick();
        src_valid = '0;
        push(0, 16'h0300, 64'h300, 1'b0);
`ifdef OSD_STM_ARB_FIXED_PRIO_EN
        push(0, 16'h0302, 64'h302, 1'b0);
        push(1, 16'h0301, 64'h301, 1'b0);
`else
        push(1, 16'h0301, 64'h301, 1'b0);
        push(0, 16'h0302, 64'h302, 1'b0);
`endif
        repeat (6) tick();
        chk("policy_drain", 64'(sb.size()), 64'd0);

        // Stall: three back-to-back events on source 1, the third is dropped.
        out_ready = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            set_src(1, 16'(16'h0400 + n), 64'(64'h4000 + n));
            src_valid = 4'b0010;
            tick();
        end
        src_valid = '0;
        push(1, 16'h0401, 64'h4001, 1'b0);
        push(1, 16'h0402, 64'h4002, 1'b1);
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_id0",   64'(out_id),    64'h401);
        repeat (3) tick();
        chk("stall_id1",   64'(out_id),    64'h401);
        chk("stall_value", 64'(out_value), 64'h4001);
        chk("stall_lost",  64'(out_lost),  64'd0);
        chk("stall_cnt1",  64'(cnt(1)),    64'd1);
        out_ready = 1'b1;
        repeat (4) tick();
        chk("stall_drain", 64'(sb.size()), 64'd0);

        // Saturation of source 0 counter, then clear coinciding with a drop.
        out_ready = 1'b0;
        for (int n = 1; n <= 300; n++) begin
            set_src(0, 16'(n), 64'(n));
            src_valid = 4'b0001;
            tick();
        end
        src_valid = '0;
        chk("sat_cnt0", 64'(cnt(0)), 64'd255);
        set_src(0, 16'hFFFF, 64'hFFFF);
        src_valid = 4'b0001;
        drop_clr  = 4'b0001;
        tick();
        src_valid = '0;
        drop_clr  = '0;
        chk("clr_drop_cnt0", 64'(cnt(0)), 64'd1);
        drop_clr = 4'b0001;
        tick();
        drop_clr = '0;
        chk("clr_cnt0", 64'(cnt(0)), 64'd0);
        push(0, 16'd1, 64'd1, 1'b0);
        push(0, 16'd2, 64'd2, 1'b1);
        out_ready = 1'b1;
        repeat (4) tick();
        chk("sat_drain", 64'(sb.size()), 64'd0);

        // Disabled source never captures.
        src_enable = 4'b0111;
        set_src(3, 16'h0500, 64'h500);
        for (int n = 0; n < 5; n++) begin
            src_valid = 4'b1000;
            tick();
            src_valid = '0;
            tick();
        end
        chk("dis_valid", 64'(out_valid), 64'd0);
        chk("dis_cnt3",  64'(cnt(3)),    64'd0);
        src_enable = '1;

        // Reset with one event in flight and one pending.
        out_ready = 1'b0;
        set_src(1, 16'h0601, 64'h601);
        set_src(2, 16'h0602, 64'h602);
        src_valid = 4'b0110;
        tick();
        src_valid = '0;
        tick();
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_src",   64'(out_src),   64'd0);
        chk("arst_id",    64'(out_id),    64'd0);
        chk("arst_value", 64'(out_value), 64'd0);
        chk("arst_lost",  64'(out_lost),  64'd0);
        chk("arst_cnt1",  64'(cnt(1)),    64'd0);
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;
        repeat (6) tick();
        chk("post_rst_valid", 64'(out_valid), 64'd0);
        chk("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
